// File: rtl/mem16_pkg.sv
// Shared constants and types for the 16 x 8-bit memory and its stream reader.
package mem16_pkg;

   localparam int unsigned MEM16_ADDR_W = 4;
   localparam int unsigned MEM16_DATA_W = 8;
   localparam int unsigned MEM16_DEPTH  = 16;
   localparam int unsigned MEM16_LEN_W  = 5;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      STREAM = 2'd2
   } rd_state_t;

   // Commands longer than the memory read each location exactly once.
   function automatic logic [MEM16_LEN_W-1:0] clamp_len(input logic [MEM16_LEN_W-1:0] len);
      return (len > MEM16_LEN_W'(MEM16_DEPTH)) ? MEM16_LEN_W'(MEM16_DEPTH) : len;
   endfunction

endpackage

// File: rtl/mem16_stream_reader.sv
// Walks LEN locations of the 16 x 8 memory from START_ADDR (wrapping) and streams them out.
// Define MEM16_READER_CLEAR_EN to zero each location as its byte is captured.
module mem16_stream_reader
   import mem16_pkg::*;
(
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_start,
   input  logic [MEM16_ADDR_W-1:0] i_start_addr,
   input  logic [MEM16_LEN_W-1:0]  i_len,
   output logic                    o_busy,
   output logic                    o_done,
   output logic [MEM16_ADDR_W-1:0] o_mem_addr,
   output logic                    o_mem_wr,
   output logic [MEM16_DATA_W-1:0] o_mem_wdata,
   input  logic [MEM16_DATA_W-1:0] i_mem_rdata,
   output logic                    o_out_valid,
   input  logic                    i_out_ready,
   output logic [MEM16_DATA_W-1:0] o_out_data,
   output logic                    o_out_last
);

   rd_state_t               r_state;
   logic [MEM16_ADDR_W-1:0] r_ptr;
   logic [MEM16_LEN_W-1:0]  r_rem;
   logic                    r_valid;
   logic [MEM16_DATA_W-1:0] r_data;
   logic                    r_last;
   logic                    r_done;
   logic                    r_busy;

   logic w_hs;
   logic w_load;

   assign w_hs   = r_valid & i_out_ready;
   // Every edge that captures a byte: the fetch edge and each non-final accepted byte.
   assign w_load = (r_state == FETCH) || ((r_state == STREAM) && w_hs && !r_last);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_ptr   <= '0;
         r_rem   <= '0;
         r_valid <= 1'b0;
         r_data  <= '0;
         r_last  <= 1'b0;
         r_done  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_load) begin
            r_data <= i_mem_rdata;
            r_last <= (r_rem == MEM16_LEN_W'(1));
            r_ptr  <= r_ptr + MEM16_ADDR_W'(1);
            r_rem  <= r_rem - MEM16_LEN_W'(1);
         end
         case (r_state)
            IDLE: begin
               if (i_start && (i_len != '0)) begin
                  r_ptr   <= i_start_addr;
                  r_rem   <= clamp_len(i_len);
                  r_busy  <= 1'b1;
                  r_state <= FETCH;
               end
            end
            FETCH: begin
               r_valid <= 1'b1;
               r_state <= STREAM;
            end
            STREAM: begin
               if (w_hs && r_last) begin
                  r_valid <= 1'b0;
                  r_last  <= 1'b0;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: begin
               r_valid <= 1'b0;
               r_last  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

`ifdef MEM16_READER_CLEAR_EN
   // Async read returns the old byte while the same edge writes zero.
   assign o_mem_wr = w_load;
`else
   assign o_mem_wr = 1'b0;
`endif

   assign o_mem_wdata = '0;
   assign o_mem_addr  = r_ptr;
   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_out_valid = r_valid;
   assign o_out_data  = r_data;
   assign o_out_last  = r_last;

endmodule

// File: doc/mem16_stream_reader.md
# mem16_stream_reader

Read-side sequencer for the 16 x 8-bit memory: on a one-cycle START command it walks LEN consecutive locations from START_ADDR, wrapping 15->0, through the memory's asynchronous read port. It streams the bytes out over a valid/ready interface with a LAST marker. It sits between the memory and any byte consumer (display driver, serial transmitter) and owns the memory's ADDR/WR pins while busy.

## Interface
- ADDR_W, 4, memory address width (depth = 2**ADDR_W = 16)
- DATA_W, 8, memory/stream data width
- CLK  in  1  system clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- START  in  1  command strobe, sampled only in IDLE
- START_ADDR  in  ADDR_W  first location to read
- LEN  in  ADDR_W+1  byte count; 0 = no-op, 17..31 clamp to 16
- BUSY  out  1  high whenever state != IDLE
- DONE  out  1  one-cycle pulse after the last byte is accepted
- MEM_ADDR  out  ADDR_W  address to memory ADDR
- MEM_WR  out  1  write strobe to memory WR
- MEM_WDATA  out  DATA_W  write data to memory DATA_IN (constant 0)
- MEM_RDATA  in  DATA_W  memory DATA_OUT (combinational read)
- OUT_VALID  out  1  OUT_DATA/OUT_LAST valid
- OUT_READY  in  1  consumer accepts when high together with OUT_VALID
- OUT_DATA  out  DATA_W  streamed byte, registered
- OUT_LAST  out  1  marks final byte of the command

## Operation
- Internal registers: ptr (ADDR_W), rem (ADDR_W+1), state in {IDLE, FETCH, STREAM}.
- Reset values:
  - State: IDLE; ptr = 0; rem = 0.
  - Outputs: OUT_VALID = 0, OUT_DATA = 0, OUT_LAST = 0, DONE = 0, BUSY = 0, MEM_WR = 0, MEM_ADDR = 0.
- MEM_ADDR = ptr in every state.
- IDLE: START=1 and LEN!=0 -> ptr<=START_ADDR, rem<=min(LEN,16), state FETCH. START with LEN=0: ignored, no DONE.
- FETCH (exactly one cycle): OUT_DATA<=MEM_RDATA, OUT_VALID<=1, OUT_LAST<=(rem==1), ptr<=ptr+1 mod 16, rem<=rem-1, state STREAM.
- STREAM, handshake (OUT_VALID & OUT_READY):
  - OUT_LAST=0: reload OUT_DATA from MEM_RDATA, ptr++, rem--, OUT_LAST<=(rem==1).
  - OUT_LAST=1: OUT_VALID<=0, OUT_LAST<=0, DONE<=1 for one cycle, state IDLE.
- STREAM, no handshake: OUT_DATA, OUT_LAST, OUT_VALID, ptr and rem held stable. Once raised, OUT_VALID never drops without a handshake.
- START while BUSY: ignored, with no queueing.
- Wrap-around: ptr increments modulo 16. START_ADDR=14, LEN=4 reads 14, 15, 0, 1.
- Reset mid-command: the stream aborts immediately with no DONE and no LAST. Memory contents are untouched, except that a clear already clocked in (see Configuration) stays.

## Timing
- START sampled at edge n -> FETCH during cycle n..n+1 -> OUT_VALID=1 after edge n+1. First-byte latency is 2 edges.
- Throughput is 1 byte/cycle with OUT_READY held high. A LEN=k command occupies k+1 BUSY cycles, plus the DONE cycle in IDLE.
- DONE is asserted in the cycle after the LAST handshake, with BUSY=0 in that same cycle. A new START is accepted in that DONE cycle.
- MEM_RDATA must settle within one cycle of MEM_ADDR changing, because it is a combinational read of registered ptr.

## Configuration
- MEM16_READER_CLEAR_EN defined:
  - Clear-on-read. MEM_WR=1 during the FETCH cycle and during every STREAM handshake cycle with OUT_LAST=0, i.e. every edge that loads OUT_DATA.
  - MEM_WDATA=0, so the location at ptr is zeroed at the same edge its old value is captured. This relies on the read-before-write behaviour of the asynchronous read.
- Undefined: MEM_WR tied 0 and the memory is never modified.

## Structure
- Shared package mem16_pkg:
  - MEM16_ADDR_W=4, MEM16_DATA_W=8, MEM16_DEPTH=16.
  - Length width MEM16_LEN_W=5.
  - State enum rd_state_t {IDLE, FETCH, STREAM}.
- Single module with no sub-module. The FSM, counters and output register are each small.

## Test plan
- Memory preloaded mem[i]=8'h10+i, START_ADDR=3, LEN=4, READY=1:
  - OUT_DATA 13, 14, 15, 16 on consecutive cycles, LAST on 16.
  - DONE one cycle later.
- Wrap: START_ADDR=14, LEN=4 -> 1E, 1F, 10, 11.
- Backpressure:
  - LEN=3 with READY toggling 1,0,0,1,... -> data and LAST held stable while READY=0.
  - Exactly 3 handshakes, no byte lost or duplicated.
- Boundary commands:
  - LEN=0 -> BUSY stays 0, no DONE.
  - LEN=20 -> 16 bytes, ending with the START_ADDR-1 byte.
  - START while BUSY -> ignored.
- RST asserted after the 2nd of 5 bytes -> all outputs return to reset values asynchronously. A following START_ADDR=0, LEN=1 returns 10.
- CLEAR_EN build: LEN=2 at address 5 -> bytes 15, 16 streamed, after which mem[5]=mem[6]=0. Non-CLEAR_EN build: MEM_WR never asserted.
